// File: rtl/mul10_seq_pkg.sv
// mul10_seq_pkg: shared widths, FSM encodings and the per-step shift table for mul10_seq
//   OP_W / HALF_W / PROD_W : operand, half-operand and product widths
//   STEP_COUNT             : partial products per operation
//   ST_IDLE/ST_MUL/ST_DONE : FSM state encodings
//   step_shift()           : left shift applied to the partial product of each step
package mul10_seq_pkg;

    localparam int OP_W       = 10;
    localparam int HALF_W     = 5;
    localparam int PROD_W     = 20;
    localparam int STEP_COUNT = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Step order is aL*bL, aL*bH, aH*bL, aH*bH, so the shifts are {0,5,5,10}.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        return (step == 2'd0) ? 4'd0 : (step == 2'd3) ? 4'd10 : 4'd5;
    endfunction

endpackage

// File: rtl/mul10_seq_wtm.sv
// mul10_seq_wtm: combinational 5x5 unsigned Wallace-tree multiplier
//   i_x : 5-bit multiplicand
//   i_y : 5-bit multiplier
//   o_p : 10-bit product (carry beyond bit 9 is dropped; a 5x5 product always fits)
module mul10_seq_wtm
    import mul10_seq_pkg::*;
(
    input  logic [HALF_W-1:0] i_x,
    input  logic [HALF_W-1:0] i_y,
    output logic [OP_W-1:0]   o_p
);

    logic [OP_W-1:0] w_pp [HALF_W];
    logic [OP_W-1:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;

    for (genvar g = 0; g < HALF_W; g++) begin : g_pp
        assign w_pp[g] = i_y[g] ? (OP_W'(i_x) << g) : '0;
    end

    // Three 3:2 carry-save layers reduce five rows to two, then one carry-propagate add.
    assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
    assign w_s3 = w_s2 ^ w_c2 ^ w_pp[4];
    assign w_c3 = ((w_s2 & w_c2) | (w_s2 & w_pp[4]) | (w_c2 & w_pp[4])) << 1;
    assign o_p  = w_s3 + w_c3;

endmodule

// File: rtl/mul10_seq.sv
// mul10_seq: sequential 10x10 unsigned multiplier, one 5x5 partial product per cycle
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready only in IDLE)
//   a, b                 : 10-bit unsigned operands
//   out_valid, out_ready : product handshake (out_valid only in DONE)
//   product              : 20-bit a*b, held while out_valid
//   busy                 : high in MUL or DONE
module mul10_seq
    import mul10_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t            r_state;
    logic [1:0]        r_step;
    logic [PROD_W-1:0] r_acc;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;

    logic [HALF_W-1:0] w_x;
    logic [HALF_W-1:0] w_y;
    logic [OP_W-1:0]   w_pp;
    logic [PROD_W-1:0] w_term;

    // step[1] picks the a half, step[0] the b half: aL*bL, aL*bH, aH*bL, aH*bH.
    assign w_x    = r_step[1] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_y    = r_step[0] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];
    assign w_term = {{(PROD_W-OP_W){1'b0}}, w_pp} << step_shift(r_step);

    mul10_seq_wtm u_wtm (
        .i_x (w_x),
        .i_y (w_y),
        .o_p (w_pp)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_acc   <= '0;
                    r_step  <= '0;
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    r_acc   <= r_acc + w_term;
                    r_step  <= r_step + 2'd1;
                    r_state <= (r_step == 2'(STEP_COUNT - 1)) ? ST_DONE : ST_MUL;
                end
                ST_DONE: if (out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_MUL) || (r_state == ST_DONE);
    assign product   = r_acc;

endmodule

// File: tb/tb_mul10_seq.sv
// tb_mul10_seq: scoreboard-based self-checking bench for mul10_seq
module tb_mul10_seq;

    logic        clock = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [9:0]  a = '0;
    logic [9:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [19:0] product;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [19:0] exp_q [$];
    logic        pending;

    mul10_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Tracks whether an accepted operation is outstanding, independent of the DUT state.
    always @(posedge clock or posedge reset) begin
        if (reset) pending <= 1'b0;
        else if (in_valid && in_ready) pending <= 1'b1;
        else if (out_valid && out_ready) pending <= 1'b0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [9:0] x, input logic [9:0] y, output bit to);
        int n = 0;
        a = x;
        b = y;
        in_valid = 1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        to = !in_ready;
        if (!to) begin
            exp_q.push_back(20'(x) * 20'(y));
            tick();
        end
        in_valid = 0;
    endtask

    task automatic wait_valid(output int cyc, output bit to);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        to = !out_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (product !== 20'd0) begin n_bad++; $display("FAIL reset_product got %0d want 0", product); end
        reset = 0;
        tick();
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_basic();
        logic [9:0]  xs [5];
        logic [9:0]  ys [5];
        logic [19:0] e;
        int          cyc;
        bit          to;
        xs[0] = 10'd1023; ys[0] = 10'd1023;
        xs[1] = 10'd0;    ys[1] = 10'd777;
        xs[2] = 10'd777;  ys[2] = 10'd0;
        xs[3] = 10'd1;    ys[3] = 10'd1;
        xs[4] = 10'd31;   ys[4] = 10'd1023;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            accept(xs[i], ys[i], to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL basic_accept_timeout pair %0d got timeout want accept", i); end
            n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy pair %0d got busy=%b ready=%b want 1/0", i, busy, in_ready); end
            wait_valid(cyc, to);
            n_cmp++; if (to || cyc !== 4) begin n_bad++; $display("FAIL basic_latency pair %0d got %0d cycles (timeout=%0d) want 4", i, cyc, to); end
            e = exp_q.size() ? exp_q.pop_front() : 'x;
            n_cmp++; if (product !== e) begin n_bad++; $display("FAIL basic_product %0d*%0d got %0d want %0d", xs[i], ys[i], product, e); end
            tick();
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_release pair %0d got valid=%b ready=%b want 0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_hold();
        logic [19:0] e;
        int          cyc;
        bit          to;
        out_ready = 0;
        accept(10'd37, 10'd600, to);
        wait_valid(cyc, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL hold_timeout got timeout want out_valid"); end
        e = exp_q.size() ? exp_q[0] : 'x;
        a = 10'd5;
        b = 10'd5;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold_cycle %0d got valid=%b product=%0d ready=%b want 1/%0d/0", i, out_valid, product, in_ready, e);
            end
            tick();
        end
        out_ready = 1;
        in_valid = 0;
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        n_cmp++; if (product !== e) begin n_bad++; $display("FAIL hold_product got %0d want %0d", product, e); end
        tick();
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_no_accept got ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  pa [3];
        logic [9:0]  pb [3];
        int          t_acc [3];
        logic [19:0] e;
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        pa[0] = 10'd5;    pb[0] = 10'd6;
        pa[1] = 10'd31;   pb[1] = 10'd32;
        pa[2] = 10'd1000; pb[2] = 10'd999;
        t_acc[0] = 0; t_acc[1] = 0; t_acc[2] = 0;
        out_ready = 1;
        a = pa[0];
        b = pb[0];
        in_valid = 1;
        while (got < 3 && cyc < 100) begin
            if (in_ready && idx < 3) begin
                exp_q.push_back(20'(pa[idx]) * 20'(pb[idx]));
                t_acc[idx] = cyc;
                idx++;
            end
            if (out_valid) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                n_cmp++; if (product !== e) begin n_bad++; $display("FAIL b2b_product %0d got %0d want %0d", got, product, e); end
                got++;
            end
            tick();
            cyc++;
            if (idx < 3) begin
                a = pa[idx];
                b = pb[idx];
            end else begin
                in_valid = 0;
            end
        end
        in_valid = 0;
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL b2b_count got %0d results want 3", got); end
        n_cmp++; if (t_acc[1] - t_acc[0] !== 6) begin n_bad++; $display("FAIL b2b_period01 got %0d want 6", t_acc[1] - t_acc[0]); end
        n_cmp++; if (t_acc[2] - t_acc[1] !== 6) begin n_bad++; $display("FAIL b2b_period12 got %0d want 6", t_acc[2] - t_acc[1]); end
    endtask

    task automatic test_async_reset();
        logic [19:0] e;
        int          cyc;
        bit          to;
        out_ready = 1;
        accept(10'd512, 10'd512, to);
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL areset_busy_before got %b want 1", busy); end
        #2 reset = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 20'd0) begin
            n_bad++; $display("FAIL areset_outputs got ready=%b valid=%b busy=%b product=%0d want 1/0/0/0", in_ready, out_valid, busy, product);
        end
        #1 reset = 0;
        exp_q.delete();
        tick();
        repeat (6) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_discard got out_valid=%b want 0", out_valid); end
            tick();
        end
        accept(10'd3, 10'd3, to);
        wait_valid(cyc, to);
        e = exp_q.size() ? exp_q.pop_front() : 'x;
        n_cmp++; if (to || product !== e) begin n_bad++; $display("FAIL areset_next got %0d (timeout=%0d) want %0d", product, to, e); end
        tick();
    endtask

    task automatic test_random();
        logic [19:0] e;
        int          cyc;
        bit          to;
        out_ready = 1;
        for (int i = 0; i < 10000; i++) begin
            accept(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), to);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rand_early_valid op %0d got 1 want 0", i); end
            wait_valid(cyc, to);
            n_cmp++; if (to || pending !== 1'b1) begin n_bad++; $display("FAIL rand_valid op %0d got timeout=%0d pending=%b want 0/1", i, to, pending); end
            e = exp_q.size() ? exp_q.pop_front() : 'x;
            n_cmp++; if (product !== e) begin n_bad++; $display("FAIL rand_product op %0d %0d*%0d got %0d want %0d", i, a, b, product, e); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
